// File: rtl/modulo_adder_pkg.sv
// Shared arithmetic helpers for small datapath leaves: ceiling log2 and an
// exact modular reduction usable at elaboration time or in combinational logic.
package modulo_adder_pkg;

   localparam int MAX_WIDTH = 32;

   function automatic int clog2(input longint unsigned v);
      int             r;
      longint unsigned p;
      r = 0;
      p = 64'd1;
      while (p < v) begin
         p = p << 1;
         r = r + 1;
      end
      return r;
   endfunction

   // A modulus of zero means "no reduction"; otherwise a true remainder, exact
   // for any sum (not limited to sum < 2*modulus).
   function automatic logic [63:0] mod_reduce(input logic [63:0] sum,
                                              input logic [63:0] modulus);
      if (modulus == 64'd0) begin
         return sum;
      end
      return sum % modulus;
   endfunction

endpackage

// File: rtl/modulo_adder_if.sv
// Operand/result bundle for modulo_adder. in_valid qualifies a/b for one edge;
// there is no ready: every valid pair is accepted, out_valid qualifies y.
interface modulo_adder_if #(
   parameter int WIDTH = 2
) ();

   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH:0]   y;
   logic             out_valid;

   modport master (
      output in_valid,
      output a,
      output b,
      input  y,
      input  out_valid
   );

   modport slave (
      input  in_valid,
      input  a,
      input  b,
      output y,
      output out_valid
   );

endinterface

// File: rtl/modulo_adder_mod_reduce.sv
// Combinational reduction of a (WIDTH+1)-bit sum modulo MODULUS; MODULUS=0
// passes the sum through unchanged.
module modulo_adder_mod_reduce
   import modulo_adder_pkg::*;
#(
   parameter int              WIDTH   = 2,
   parameter longint unsigned MODULUS = 0
) (
   input  logic [WIDTH:0] i_sum,
   output logic [WIDTH:0] o_red
);

   localparam int SW = WIDTH + 1;

   assign o_red = SW'(mod_reduce(64'(i_sum), 64'(MODULUS)));

endmodule

// File: rtl/modulo_adder.sv
// Registered unsigned adder with optional modular reduction; result and
// out_valid appear one clock after an accepted operand pair.
module modulo_adder
   import modulo_adder_pkg::*;
#(
   parameter int              WIDTH   = 2,
   parameter longint unsigned MODULUS = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   modulo_adder_if.slave bus
);

   if ((WIDTH < 1) || (WIDTH > MAX_WIDTH)) begin : g_bad_width
      $fatal(1, "modulo_adder: WIDTH must be in 1..32");
   end

   if (MODULUS > (64'd1 << (WIDTH + 1))) begin : g_bad_modulus
      $fatal(1, "modulo_adder: MODULUS must be 0 or in 1..2^(WIDTH+1)");
   end

   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_red;
   logic [WIDTH:0] r_y;
   logic           r_out_valid;

   // Zero-extend before adding so the carry lands in the top bit.
   assign w_sum = {1'b0, bus.a} + {1'b0, bus.b};

   modulo_adder_mod_reduce #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_mod_reduce (
      .i_sum (w_sum),
      .o_red (w_red)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y         <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_y <= w_red;
         end
      end
   end

   assign bus.y         = r_y;
   assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_modulo_adder.sv
// Bench for modulo_adder: three instances (2-bit plain, 2-bit mod 5, 8-bit
// plain) driven at the falling edge and checked just after the rising edge.
module tb_modulo_adder;

   logic clk;
   logic rst_n;

   modulo_adder_if #(.WIDTH(2)) if0 ();
   modulo_adder_if #(.WIDTH(2)) if5 ();
   modulo_adder_if #(.WIDTH(8)) if8 ();

   modulo_adder #(.WIDTH(2), .MODULUS(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   modulo_adder #(.WIDTH(2), .MODULUS(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(if5));
   modulo_adder #(.WIDTH(8), .MODULUS(0)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

   logic [2:0] exp_q0[$];
   logic [2:0] exp_q5[$];
   logic [8:0] exp_q8[$];

   int n_vec  = 0;
   int n_fail = 0;

   // clock/reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [2:0] mod5(input int s);
      int r;
      r = s;
      while (r >= 5) r = r - 5;
      return 3'(r);
   endfunction

   // driver: apply inputs at the falling edge, return just after the rising edge
   task automatic drive(input logic [2:0] sel, input logic [1:0] a2, input logic [1:0] b2,
                        input logic [7:0] a8, input logic [7:0] b8);
      @(negedge clk);
      if0.in_valid = sel[0]; if0.a = a2; if0.b = b2;
      if5.in_valid = sel[1]; if5.a = a2; if5.b = b2;
      if8.in_valid = sel[2]; if8.a = a8; if8.b = b8;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      if0.in_valid = 1'b0; if0.a = '0; if0.b = '0;
      if5.in_valid = 1'b0; if5.a = '0; if5.b = '0;
      if8.in_valid = 1'b0; if8.a = '0; if8.b = '0;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if ({if0.out_valid, if0.y} !== 4'b0) begin
         n_fail++; $display("FAIL reset_dut0: got %b expected 0000", {if0.out_valid, if0.y});
      end
      n_vec++;
      if ({if5.out_valid, if5.y} !== 4'b0) begin
         n_fail++; $display("FAIL reset_dut5: got %b expected 0000", {if5.out_valid, if5.y});
      end
      n_vec++;
      if ({if8.out_valid, if8.y} !== 10'b0) begin
         n_fail++; $display("FAIL reset_dut8: got %b expected 0", {if8.out_valid, if8.y});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_exhaustive();
      logic [2:0] exp;
      for (int a = 0; a < 4; a++) begin
         for (int b = 0; b < 4; b++) begin
            exp_q0.push_back(3'(a + b));
            drive(3'b001, 2'(a), 2'(b), 8'd0, 8'd0);
            exp = exp_q0.pop_front();
            n_vec++;
            if (if0.out_valid !== 1'b1) begin
               n_fail++; $display("FAIL exhaustive_valid a=%0d b=%0d: got %b expected 1", a, b, if0.out_valid);
            end
            n_vec++;
            if (if0.y !== exp) begin
               n_fail++; $display("FAIL exhaustive_y a=%0d b=%0d: got %0d expected %0d", a, b, if0.y, exp);
            end
         end
      end
   endtask

   task automatic test_valid_gating();
      exp_q0.push_back(3'd1);
      drive(3'b001, 2'd0, 2'd1, 8'd0, 8'd0);
      n_vec++;
      if (if0.y !== exp_q0.pop_front()) begin
         n_fail++; $display("FAIL gating_prior: got %0d expected 1", if0.y);
      end
      drive(3'b000, 2'd2, 2'd3, 8'd0, 8'd0);
      n_vec++;
      if (if0.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL gating_valid: got %b expected 0", if0.out_valid);
      end
      n_vec++;
      if (if0.y !== 3'd1) begin
         n_fail++; $display("FAIL gating_hold: got %0d expected 1", if0.y);
      end
   endtask

   task automatic test_async_reset();
      exp_q0.push_back(3'd2);
      drive(3'b001, 2'd1, 2'd1, 8'd0, 8'd0);
      n_vec++;
      if (if0.y !== exp_q0.pop_front()) begin
         n_fail++; $display("FAIL areset_prior: got %0d expected 2", if0.y);
      end
      @(negedge clk);
      if0.in_valid = 1'b1; if0.a = 2'd3; if0.b = 2'd3;
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({if0.out_valid, if0.y} !== 4'b0) begin
         n_fail++; $display("FAIL areset_immediate: got %b expected 0000", {if0.out_valid, if0.y});
      end
      @(posedge clk);
      #1;
      n_vec++;
      if ({if0.out_valid, if0.y} !== 4'b0) begin
         n_fail++; $display("FAIL areset_held: got %b expected 0000", {if0.out_valid, if0.y});
      end
      @(negedge clk);
      if0.in_valid = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         n_vec++;
         if ({if0.out_valid, if0.y} !== 4'b0) begin
            n_fail++; $display("FAIL areset_release%0d: got %b expected 0000", i, {if0.out_valid, if0.y});
         end
      end
      exp_q0.push_back(3'd6);
      drive(3'b001, 2'd3, 2'd3, 8'd0, 8'd0);
      n_vec++;
      if ({if0.out_valid, if0.y} !== {1'b1, exp_q0.pop_front()}) begin
         n_fail++; $display("FAIL areset_first: got %b expected 1110", {if0.out_valid, if0.y});
      end
   endtask

   task automatic test_modular();
      logic [1:0] ta [4];
      logic [1:0] tb [4];
      logic [2:0] ty [4];
      logic [2:0] exp;
      ta = '{2'd3, 2'd2, 2'd3, 2'd0};
      tb = '{2'd3, 2'd2, 2'd2, 2'd1};
      ty = '{3'd1, 3'd4, 3'd0, 3'd1};
      for (int i = 0; i < 4; i++) begin
         exp_q5.push_back(ty[i]);
         drive(3'b010, ta[i], tb[i], 8'd0, 8'd0);
         exp = exp_q5.pop_front();
         n_vec++;
         if ({if5.out_valid, if5.y} !== {1'b1, exp}) begin
            n_fail++; $display("FAIL modular a=%0d b=%0d: got valid=%b y=%0d expected valid=1 y=%0d",
                               ta[i], tb[i], if5.out_valid, if5.y, exp);
         end
      end
   endtask

   task automatic test_wide();
      logic [7:0] ta [2];
      logic [7:0] tb [2];
      logic [8:0] ty [2];
      logic [8:0] exp;
      ta = '{8'd255, 8'd128};
      tb = '{8'd255, 8'd127};
      ty = '{9'd510, 9'd255};
      for (int i = 0; i < 2; i++) begin
         exp_q8.push_back(ty[i]);
         drive(3'b100, 2'd0, 2'd0, ta[i], tb[i]);
         exp = exp_q8.pop_front();
         n_vec++;
         if ({if8.out_valid, if8.y} !== {1'b1, exp}) begin
            n_fail++; $display("FAIL wide a=%0d b=%0d: got valid=%b y=%0d expected valid=1 y=%0d",
                               ta[i], tb[i], if8.out_valid, if8.y, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] ra, rb;
      logic [7:0] wa, wb;
      logic [2:0] e0, e5;
      logic [8:0] e8;
      for (int i = 0; i < 16; i++) begin
         ra = 2'($urandom_range(0, 3));
         rb = 2'($urandom_range(0, 3));
         wa = 8'($urandom_range(0, 255));
         wb = 8'($urandom_range(0, 255));
         exp_q0.push_back(3'(int'(ra) + int'(rb)));
         exp_q5.push_back(mod5(int'(ra) + int'(rb)));
         exp_q8.push_back(9'(int'(wa) + int'(wb)));
         drive(3'b111, ra, rb, wa, wb);
         e0 = exp_q0.pop_front();
         e5 = exp_q5.pop_front();
         e8 = exp_q8.pop_front();
         n_vec++;
         if ({if0.out_valid, if0.y} !== {1'b1, e0}) begin
            n_fail++; $display("FAIL stream_dut0 #%0d: got valid=%b y=%0d expected valid=1 y=%0d", i, if0.out_valid, if0.y, e0);
         end
         n_vec++;
         if ({if5.out_valid, if5.y} !== {1'b1, e5}) begin
            n_fail++; $display("FAIL stream_dut5 #%0d: got valid=%b y=%0d expected valid=1 y=%0d", i, if5.out_valid, if5.y, e5);
         end
         n_vec++;
         if ({if8.out_valid, if8.y} !== {1'b1, e8}) begin
            n_fail++; $display("FAIL stream_dut8 #%0d: got valid=%b y=%0d expected valid=1 y=%0d", i, if8.out_valid, if8.y, e8);
         end
      end
      drive(3'b000, 2'd0, 2'd0, 8'd0, 8'd0);
      n_vec++;
      if ({if0.out_valid, if5.out_valid, if8.out_valid} !== 3'b000) begin
         n_fail++; $display("FAIL stream_end: got %b expected 000", {if0.out_valid, if5.out_valid, if8.out_valid});
      end
   endtask

   initial begin
      test_reset();
      test_exhaustive();
      test_valid_gating();
      test_async_reset();
      test_modular();
      test_wide();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/modulo_adder.md
# modulo_adder

Registered unsigned adder with optional modular reduction. Takes two WIDTH-bit operands, produces their full (WIDTH+1)-bit sum, or the sum reduced modulo MODULUS, one clock after the operands are presented. It sits in the datapath as a small arithmetic leaf; the default configuration (WIDTH=2, MODULUS=0) is the 2-bit adder with 3-bit result that the rest of the design uses. RTL module name: modulo_adder.

## Interface
- WIDTH, default 2: operand width in bits, legal range 1..32.
- MODULUS, default 0: 0 = no reduction, y is the full sum. Otherwise y = (a+b) mod MODULUS, legal range 1..2^(WIDTH+1).
- One clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a and b are valid this cycle.
- a  input  WIDTH  unsigned operand A.
- b  input  WIDTH  unsigned operand B.
- y  output  WIDTH+1  registered result.
- out_valid  output  1  y holds the result of an accepted operand pair.

## Operation
- Sum: s = a + b computed at WIDTH+1 bits, zero-extended, unsigned. It never overflows (max 2^(WIDTH+1)-2).
- MODULUS=0: y <= s.
- MODULUS>0: y <= s mod MODULUS, combinational and exact for every s in range. Because s < 2*MODULUS is not guaranteed in general, use a true remainder or a repeated conditional-subtract chain; a single subtract is not sufficient.
- Result is zero-extended to WIDTH+1 bits.
- in_valid=1 at a rising edge: y and out_valid=1 are loaded.
- in_valid=0 at a rising edge: out_valid <= 0, and y holds its previous value (no update).
- The block always accepts input. There is no ready and no backpressure.

## Timing
- Latency: exactly 1 cycle from the edge that samples in_valid=1 to y/out_valid visible.
- Throughput: one operation per cycle; back-to-back valid inputs give back-to-back results.
- Reset: rst_n low forces y=0 and out_valid=0 immediately, independent of clk. Reset asserted mid-stream discards the in-flight result.
- First valid result after reset release: 1 cycle after the first edge with in_valid=1 and rst_n=1.
- Outputs are purely registered, with no combinational path from inputs to outputs.

## Structure
- Shared package (e.g. arith_pkg): a function clog2 and a function mod_reduce(sum, modulus) for reuse by other arithmetic leaves. No typedefs are required.
- One combinational sub-module, mod_reduce, is natural: input (WIDTH+1) bits, parameter MODULUS, output the reduced value. modulo_adder = adder + mod_reduce + output register.
- Add elaboration-time checks: WIDTH in 1..32, and MODULUS either 0 or in 1..2^(WIDTH+1); otherwise fatal.

## Test plan
- Exhaustive, default params: for a=0..3, b=0..3, hold each pair with in_valid=1 for one cycle -> next cycle y=a+b (e.g. 3+3 -> 6, 2+1 -> 3, 0+0 -> 0), out_valid=1.
- Valid gating: a=2, b=3, in_valid=0 after a prior result y=1 -> out_valid=0, y stays 1.
- Async reset: drive a=3, b=3, in_valid=1, then pull rst_n low between edges -> y=0 and out_valid=0 immediately. After release, no result appears until a new valid input is presented.
- Modular mode, WIDTH=2, MODULUS=5: (3,3) -> 1, (2,2) -> 4, (3,2) -> 0, (0,1) -> 1.
- Back-to-back streaming: 16 consecutive valid pairs -> 16 consecutive results, each aligned one cycle after its input, with no bubbles.
- Wide config, WIDTH=8, MODULUS=0: (255,255) -> 510, (128,127) -> 255.
